csr_file: RTL and testbench
===========================

Name: csr_file

Overview:
Machine-mode CSR register file sitting directly downstream of the execute stage. It consumes the registered CSR write-back, trap and mret outputs of execute, and commits them into architectural CSR state. It provides a combinational CSR read port to decode, and returns mepc/mtvec to execute for trap and mret redirection. It also holds the 64-bit mcycle/minstret counters.

Parameters:
XLEN, 32, data width; only 32 supported.
MTVEC_RESET, 32'h0000_0000, reset value of mtvec.
MISA_VALUE, 32'h4000_0100, constant read value of misa (RV32I).

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
csr_rd_adr_i  input  12  decode read address
csr_rd_wr_intent_i  input  1  decoded instruction intends to write the addressed CSR
csr_rd_data_o  output  XLEN  combinational read data for csr_rd_adr_i
csr_rd_illegal_o  output  1  unimplemented address, or write intent to a read-only CSR
csr_wbk_v_q_i  input  1  CSR write valid from execute
csr_adr_q_i  input  12  CSR write address
csr_data_q_i  input  XLEN  CSR write data
exception_q_i  input  1  trap commit pulse
mcause_q_i  input  XLEN  trap cause
mtval_q_i  input  XLEN  trap value
mepc_q_i  input  XLEN  faulting PC
core_mode_q_i  input  2  privilege mode before the trap
mret_q_i  input  1  mret commit pulse
retire_v_i  input  1  one instruction retired this cycle
mepc_q_o  output  XLEN  current mepc
mtvec_q_o  output  XLEN  current mtvec
mstatus_q_o  output  XLEN  current mstatus

Behaviour:
- Implemented CSRs:
  - mstatus 0x300: only MIE[3], MPIE[7] and MPP[12:11] are stored; other bits read 0.
  - misa 0x301: reads MISA_VALUE; writes are ignored but legal.
  - mie 0x304: 32-bit read/write.
  - mtvec 0x305: bits[1:0] forced to 0 (direct mode).
  - mscratch 0x340: 32-bit read/write.
  - mepc 0x341: bits[1:0] forced to 0.
  - mcause 0x342, mtval 0x343: 32-bit read/write.
  - mip 0x344: reads 0; writes ignored.
  - mcycle 0xB00 / mcycleh 0xB80, minstret 0xB02 / minstreth 0xB82: read/write.
  - cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82: read-only shadows.
  - mhartid 0xF14: reads 0, read-only.
- Reset (reset=1 at a clock edge):
  - mtvec = MTVEC_RESET; mstatus.MPP = 2'b11.
  - All other stored state = 0, including both counters.
  - Outputs reflect these values in the cycle after the edge.
  - Reset asserted mid-operation overrides any write, trap or mret in that cycle.
- Read port:
  - Purely combinational from current register state; no bypass of a same-cycle write. Decode/execute forwarding covers that hazard.
  - csr_rd_illegal_o = 1 when the address is not in the list above, or when csr_rd_wr_intent_i=1 and csr_rd_adr_i[11:10]==2'b11.
  - An illegal address reads 0.
- Write (csr_wbk_v_q_i=1): takes effect at the next edge.
  - Writes to read-only or unimplemented addresses are silently dropped.
- Trap (exception_q_i=1), applied at the next edge:
  - mepc <= {mepc_q_i[31:2], 2'b00}; mcause <= mcause_q_i; mtval <= mtval_q_i.
  - MPIE <= MIE; MIE <= 0; MPP <= core_mode_q_i.
- mret (mret_q_i=1), applied at the next edge: MIE <= MPIE; MPIE <= 1; MPP <= 2'b00.
- Simultaneous events, priority exception > mret > csr write:
  - Exception with mret: mret ignored.
  - Exception or mret with a CSR write: the write is dropped entirely, even to an unrelated CSR. The trapping instruction does not commit.
- mcycle:
  - Increments by 1 every non-reset cycle as one 64-bit value; it wraps 2^64-1 -> 0.
  - A write to the low or high half replaces that half with the write data. No increment occurs that cycle (the written value is exactly what is held next cycle).
- minstret:
  - Increments when retire_v_i=1, with the same write-override rule.
  - retire_v_i is ignored in a cycle with exception_q_i=1.
- Carry: low-half overflow (0xFFFF_FFFF -> 0) increments the high half in the same edge.

Test Plan:
- Reset, then read 0x305 / 0x300 / 0xB00 -> MTVEC_RESET / 0x0000_1800 / 0; a cycle later 0xB00 reads 1.
- Write mtvec 0x8000_0103 -> mtvec_q_o = 0x8000_0100 next cycle; csr_rd_adr_i = 0x7C0 -> csr_rd_illegal_o = 1, read data 0.
- Set MIE = 1, then trap with mepc 0x0000_1006, mcause 2, mode 2'b00 -> mepc 0x0000_1004, mcause 2, mstatus 0x0000_0080. A following mret -> mstatus 0x0000_0088.
- In one cycle, exception plus a CSR write of mscratch=0x1234 plus mret -> trap applied, mscratch unchanged, MPP = core_mode_q_i.
- Write mcycle = 0xFFFF_FFFF -> next cycle mcycle 0xFFFF_FFFF; the following cycle mcycle 0, mcycleh 1.
- Pulse retire_v_i 3 times with one pulse coinciding with exception_q_i -> minstret = 2. csr_rd_wr_intent_i=1 at 0xC02 -> illegal = 1; a write to 0xC02 leaves minstret unchanged.

Source files
------------

// File: rtl/csr_file_if.sv
// csr_file_if
//   Groups the CSR-file connections to decode and execute: the
//   combinational read port used by decode, the registered write-back /
//   trap / mret commit stream from execute, the retire strobe, and the
//   mepc/mtvec/mstatus values returned to execute for redirection.
//   master : decode/execute side (drives reads, write-back, trap, mret)
//   slave  : csr_file side (returns read data and architectural state)
interface csr_file_if #(
  parameter int XLEN = 32
);
  // decode read port
  logic [11:0]     csr_rd_adr_i;
  logic            csr_rd_wr_intent_i;
  logic [XLEN-1:0] csr_rd_data_o;
  logic            csr_rd_illegal_o;
  // execute commit stream
  logic            csr_wbk_v_q_i;
  logic [11:0]     csr_adr_q_i;
  logic [XLEN-1:0] csr_data_q_i;
  logic            exception_q_i;
  logic [XLEN-1:0] mcause_q_i;
  logic [XLEN-1:0] mtval_q_i;
  logic [XLEN-1:0] mepc_q_i;
  logic [1:0]      core_mode_q_i;
  logic            mret_q_i;
  logic            retire_v_i;
  // state returned to execute
  logic [XLEN-1:0] mepc_q_o;
  logic [XLEN-1:0] mtvec_q_o;
  logic [XLEN-1:0] mstatus_q_o;

  modport master (
    output csr_rd_adr_i, csr_rd_wr_intent_i,
    output csr_wbk_v_q_i, csr_adr_q_i, csr_data_q_i,
    output exception_q_i, mcause_q_i, mtval_q_i, mepc_q_i, core_mode_q_i,
    output mret_q_i, retire_v_i,
    input  csr_rd_data_o, csr_rd_illegal_o,
    input  mepc_q_o, mtvec_q_o, mstatus_q_o
  );

  modport slave (
    input  csr_rd_adr_i, csr_rd_wr_intent_i,
    input  csr_wbk_v_q_i, csr_adr_q_i, csr_data_q_i,
    input  exception_q_i, mcause_q_i, mtval_q_i, mepc_q_i, core_mode_q_i,
    input  mret_q_i, retire_v_i,
    output csr_rd_data_o, csr_rd_illegal_o,
    output mepc_q_o, mtvec_q_o, mstatus_q_o
  );
endinterface

// File: rtl/csr_file.sv
// csr_file
//   Machine-mode CSR register file downstream of execute. Commits CSR
//   writes, traps and mret into architectural state, serves a
//   combinational read port to decode and holds mcycle/minstret.
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous active-high reset
//   bus   : csr_file_if.slave (read port, commit stream, state outputs)
module csr_file #(
  parameter int          XLEN        = 32,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
  input logic         clk,
  input logic         reset,
  csr_file_if.slave   bus
);

  localparam logic [11:0] ADR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADR_MISA      = 12'h301;
  localparam logic [11:0] ADR_MIE       = 12'h304;
  localparam logic [11:0] ADR_MTVEC     = 12'h305;
  localparam logic [11:0] ADR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADR_MEPC      = 12'h341;
  localparam logic [11:0] ADR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADR_MTVAL     = 12'h343;
  localparam logic [11:0] ADR_MIP       = 12'h344;
  localparam logic [11:0] ADR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADR_INSTRETH  = 12'hC82;
  localparam logic [11:0] ADR_MHARTID   = 12'hF14;

  // Low two bits cleared for mepc/mtvec (word-aligned, direct mode).
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  logic        mstatus_mie_r;
  logic        mstatus_mpie_r;
  logic [1:0]  mstatus_mpp_r;
  logic [31:0] mie_r;
  logic [31:0] mtvec_r;
  logic [31:0] mscratch_r;
  logic [31:0] mepc_r;
  logic [31:0] mcause_r;
  logic [31:0] mtval_r;
  logic [63:0] mcycle_r;
  logic [63:0] minstret_r;

  logic        commit_wr_s;
  logic [31:0] rd_data_s;
  logic        rd_known_s;
  logic        rd_illegal_s;

  // mstatus view: MIE[3], MPIE[7], MPP[12:11], everything else zero.
  function automatic logic [31:0] pack_mstatus(input logic mie,
                                               input logic mpie,
                                               input logic [1:0] mpp);
    return {19'd0, mpp, 3'd0, mpie, 3'd0, mie, 3'd0};
  endfunction

  // A CSR write commits only when neither a trap nor an mret retires with
  // it: the trapping instruction never commits its write.
  always_comb begin
    commit_wr_s = bus.csr_wbk_v_q_i & ~bus.exception_q_i & ~bus.mret_q_i;
  end

  // Architectural CSR state: reset > trap > mret > CSR write.
  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus_mie_r  <= 1'b0;
      mstatus_mpie_r <= 1'b0;
      mstatus_mpp_r  <= 2'b11;
      mie_r          <= 32'd0;
      mtvec_r        <= MTVEC_RESET;
      mscratch_r     <= 32'd0;
      mepc_r         <= 32'd0;
      mcause_r       <= 32'd0;
      mtval_r        <= 32'd0;
    end else if (bus.exception_q_i) begin
      mepc_r         <= bus.mepc_q_i & ALIGN_MASK;
      mcause_r       <= bus.mcause_q_i;
      mtval_r        <= bus.mtval_q_i;
      mstatus_mpie_r <= mstatus_mie_r;
      mstatus_mie_r  <= 1'b0;
      mstatus_mpp_r  <= bus.core_mode_q_i;
    end else if (bus.mret_q_i) begin
      mstatus_mie_r  <= mstatus_mpie_r;
      mstatus_mpie_r <= 1'b1;
      mstatus_mpp_r  <= 2'b00;
    end else if (commit_wr_s) begin
      case (bus.csr_adr_q_i)
        ADR_MSTATUS: begin
          mstatus_mie_r  <= bus.csr_data_q_i[3];
          mstatus_mpie_r <= bus.csr_data_q_i[7];
          mstatus_mpp_r  <= bus.csr_data_q_i[12:11];
        end
        ADR_MIE:      mie_r      <= bus.csr_data_q_i;
        ADR_MTVEC:    mtvec_r    <= bus.csr_data_q_i & ALIGN_MASK;
        ADR_MSCRATCH: mscratch_r <= bus.csr_data_q_i;
        ADR_MEPC:     mepc_r     <= bus.csr_data_q_i & ALIGN_MASK;
        ADR_MCAUSE:   mcause_r   <= bus.csr_data_q_i;
        ADR_MTVAL:    mtval_r    <= bus.csr_data_q_i;
        default: begin
          // read-only, ignored or unimplemented: write dropped
        end
      endcase
    end else begin
      mie_r <= mie_r;
    end
  end

  // mcycle: a written half is held exactly; otherwise +1 with carry.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcycle_r <= 64'd0;
    end else if (commit_wr_s && (bus.csr_adr_q_i == ADR_MCYCLE)) begin
      mcycle_r <= {mcycle_r[63:32], bus.csr_data_q_i};
    end else if (commit_wr_s && (bus.csr_adr_q_i == ADR_MCYCLEH)) begin
      mcycle_r <= {bus.csr_data_q_i, mcycle_r[31:0]};
    end else begin
      mcycle_r <= mcycle_r + 64'd1;
    end
  end

  // minstret: same write override; a retire alongside a trap is not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      minstret_r <= 64'd0;
    end else if (commit_wr_s && (bus.csr_adr_q_i == ADR_MINSTRET)) begin
      minstret_r <= {minstret_r[63:32], bus.csr_data_q_i};
    end else if (commit_wr_s && (bus.csr_adr_q_i == ADR_MINSTRETH)) begin
      minstret_r <= {bus.csr_data_q_i, minstret_r[31:0]};
    end else if (bus.retire_v_i && !bus.exception_q_i) begin
      minstret_r <= minstret_r + 64'd1;
    end else begin
      minstret_r <= minstret_r;
    end
  end

  // Combinational read decode; no bypass of a same-cycle write.
  always_comb begin
    rd_data_s  = 32'd0;
    rd_known_s = 1'b1;
    case (bus.csr_rd_adr_i)
      ADR_MSTATUS:   rd_data_s = pack_mstatus(mstatus_mie_r, mstatus_mpie_r, mstatus_mpp_r);
      ADR_MISA:      rd_data_s = MISA_VALUE;
      ADR_MIE:       rd_data_s = mie_r;
      ADR_MTVEC:     rd_data_s = mtvec_r;
      ADR_MSCRATCH:  rd_data_s = mscratch_r;
      ADR_MEPC:      rd_data_s = mepc_r;
      ADR_MCAUSE:    rd_data_s = mcause_r;
      ADR_MTVAL:     rd_data_s = mtval_r;
      ADR_MIP:       rd_data_s = 32'd0;
      ADR_MCYCLE,
      ADR_CYCLE:     rd_data_s = mcycle_r[31:0];
      ADR_MCYCLEH,
      ADR_CYCLEH:    rd_data_s = mcycle_r[63:32];
      ADR_MINSTRET,
      ADR_INSTRET:   rd_data_s = minstret_r[31:0];
      ADR_MINSTRETH,
      ADR_INSTRETH:  rd_data_s = minstret_r[63:32];
      ADR_MHARTID:   rd_data_s = 32'd0;
      default: begin
        rd_data_s  = 32'd0;
        rd_known_s = 1'b0;
      end
    endcase
    // Address space 0xC00-0xFFF is read-only by encoding.
    if (bus.csr_rd_wr_intent_i && (bus.csr_rd_adr_i[11:10] == 2'b11)) begin
      rd_illegal_s = 1'b1;
    end else begin
      rd_illegal_s = ~rd_known_s;
    end
  end

  assign bus.csr_rd_data_o    = rd_data_s;
  assign bus.csr_rd_illegal_o = rd_illegal_s;
  assign bus.mepc_q_o         = mepc_r;
  assign bus.mtvec_q_o        = mtvec_r;
  assign bus.mstatus_q_o      = pack_mstatus(mstatus_mie_r, mstatus_mpie_r, mstatus_mpp_r);

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file
//   Self-checking bench for csr_file: a table of write-then-read vectors
//   plus hand-written trap/mret/counter/reset sequences. Expected values
//   are queued on a scoreboard when stimulus is driven and compared when
//   the DUT outputs are sampled.
module tb_csr_file;

  localparam logic [31:0] MTV = 32'h0000_0200;

  logic clk;
  logic reset;

  csr_file_if #(.XLEN(32)) bus ();

  csr_file #(.XLEN(32), .MTVEC_RESET(MTV), .MISA_VALUE(32'h4000_0100)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    int          sel;   // 0 rd_data, 1 rd_illegal, 2 mepc, 3 mtvec, 4 mstatus
    logic [31:0] exp;
  } exp_t;

  typedef struct {
    logic [11:0] adr;
    logic [31:0] wdata;
    logic        intent;
    logic [31:0] exp;
    logic        exp_ill;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[14];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0: return bus.csr_rd_data_o;
      1: return {31'd0, bus.csr_rd_illegal_o};
      2: return bus.mepc_q_o;
      3: return bus.mtvec_q_o;
      4: return bus.mstatus_q_o;
      default: return 32'hDEAD_DEAD;
    endcase
  endfunction

  task automatic push(input string nm, input int sel, input logic [31:0] exp);
    exp_t e;
    e.nm = nm; e.sel = sel; e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Let the combinational outputs settle, then compare everything queued.
  task automatic drain();
    exp_t e;
    logic [31:0] act;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      act = observe(e.sel);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.nm, act, e.exp);
      end
    end
  endtask

  task automatic rd(input string nm, input logic [11:0] adr, input logic intent,
                    input logic [31:0] exp, input logic exp_ill);
    bus.csr_rd_adr_i       = adr;
    bus.csr_rd_wr_intent_i = intent;
    push({nm, "_data"}, 0, exp);
    push({nm, "_ill"}, 1, {31'd0, exp_ill});
    drain();
  endtask

  task automatic outchk(input string nm, input int sel, input logic [31:0] exp);
    push(nm, sel, exp);
    drain();
  endtask

  task automatic wr(input logic [11:0] adr, input logic [31:0] data);
    bus.csr_wbk_v_q_i = 1'b1;
    bus.csr_adr_q_i   = adr;
    bus.csr_data_q_i  = data;
  endtask

  task automatic trap(input logic [31:0] epc, input logic [31:0] cause,
                      input logic [31:0] tval, input logic [1:0] mode);
    bus.exception_q_i = 1'b1;
    bus.mepc_q_i      = epc;
    bus.mcause_q_i    = cause;
    bus.mtval_q_i     = tval;
    bus.core_mode_q_i = mode;
  endtask

  // One clock edge, then drop the single-cycle commit pulses.
  task automatic step();
    @(posedge clk);
    #1;
    bus.csr_wbk_v_q_i = 1'b0;
    bus.exception_q_i = 1'b0;
    bus.mret_q_i      = 1'b0;
    bus.retire_v_i    = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{12'h305, 32'h8000_0103, 1'b0, 32'h8000_0100, 1'b0};
    vecs[1]  = '{12'h340, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{12'h341, 32'h1234_5677, 1'b0, 32'h1234_5674, 1'b0};
    vecs[3]  = '{12'h342, 32'h8000_000B, 1'b0, 32'h8000_000B, 1'b0};
    vecs[4]  = '{12'h343, 32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5, 1'b0};
    vecs[5]  = '{12'h304, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{12'h301, 32'h0000_0000, 1'b0, 32'h4000_0100, 1'b0};
    vecs[7]  = '{12'h344, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0};
    vecs[8]  = '{12'h300, 32'hFFFF_FFFF, 1'b0, 32'h0000_1888, 1'b0};
    vecs[9]  = '{12'hF14, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b0};
    vecs[10] = '{12'hF14, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b1};
    vecs[11] = '{12'h7C0, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
    vecs[12] = '{12'h301, 32'h0000_0000, 1'b1, 32'h4000_0100, 1'b0};
    vecs[13] = '{12'h300, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};

    reset                  = 1'b1;
    bus.csr_rd_adr_i       = 12'h000;
    bus.csr_rd_wr_intent_i = 1'b0;
    bus.csr_wbk_v_q_i      = 1'b0;
    bus.csr_adr_q_i        = 12'h000;
    bus.csr_data_q_i       = 32'd0;
    bus.exception_q_i      = 1'b0;
    bus.mcause_q_i         = 32'd0;
    bus.mtval_q_i          = 32'd0;
    bus.mepc_q_i           = 32'd0;
    bus.core_mode_q_i      = 2'b00;
    bus.mret_q_i           = 1'b0;
    bus.retire_v_i         = 1'b0;

    // Reset state
    step();
    step();
    rd("rst_mtvec", 12'h305, 1'b0, MTV, 1'b0);
    rd("rst_mstatus", 12'h300, 1'b0, 32'h0000_1800, 1'b0);
    rd("rst_mcycle", 12'hB00, 1'b0, 32'd0, 1'b0);
    outchk("rst_mepc_o", 2, 32'd0);
    reset = 1'b0;
    step();
    rd("mcycle_first", 12'hB00, 1'b0, 32'd1, 1'b0);

    // Table: write, then read back through the decode port
    for (int i = 0; i < 14; i++) begin
      wr(vecs[i].adr, vecs[i].wdata);
      step();
      rd($sformatf("vec%0d", i), vecs[i].adr, vecs[i].intent, vecs[i].exp, vecs[i].exp_ill);
    end
    outchk("mtvec_o", 3, 32'h8000_0100);
    outchk("mepc_o", 2, 32'h1234_5674);
    outchk("mstatus_o_cleared", 4, 32'd0);
    rd("c02_intent", 12'hC02, 1'b1, 32'd0, 1'b1);
    rd("b02_intent", 12'hB02, 1'b1, 32'd0, 1'b0);

    // Trap with MIE set, then mret
    wr(12'h300, 32'h0000_0008);
    step();
    outchk("mie_set", 4, 32'h0000_0008);
    trap(32'h0000_1006, 32'd2, 32'h0000_0055, 2'b00);
    step();
    outchk("trap_mepc", 2, 32'h0000_1004);
    rd("trap_mcause", 12'h342, 1'b0, 32'd2, 1'b0);
    rd("trap_mtval", 12'h343, 1'b0, 32'h0000_0055, 1'b0);
    outchk("trap_mstatus", 4, 32'h0000_0080);
    bus.mret_q_i = 1'b1;
    step();
    outchk("mret_mstatus", 4, 32'h0000_0088);

    // Exception + write + mret together: only the trap applies
    trap(32'h0000_2002, 32'd7, 32'h0000_0011, 2'b01);
    wr(12'h340, 32'h0000_1234);
    bus.mret_q_i = 1'b1;
    step();
    rd("combo_mscratch", 12'h340, 1'b0, 32'hDEAD_BEEF, 1'b0);
    outchk("combo_mstatus", 4, 32'h0000_0880);
    outchk("combo_mepc", 2, 32'h0000_2000);

    // mret + write: write dropped, mret applies
    wr(12'h340, 32'h0000_0077);
    bus.mret_q_i = 1'b1;
    step();
    rd("mret_wr_mscratch", 12'h340, 1'b0, 32'hDEAD_BEEF, 1'b0);
    outchk("mret_wr_mstatus", 4, 32'h0000_0088);

    // mcycle write holds exactly, then carries into the high half
    wr(12'hB00, 32'hFFFF_FFFF);
    step();
    rd("mcycle_wr", 12'hB00, 1'b0, 32'hFFFF_FFFF, 1'b0);
    rd("mcycleh_pre", 12'hB80, 1'b0, 32'd0, 1'b0);
    step();
    rd("mcycle_wrap", 12'hB00, 1'b0, 32'd0, 1'b0);
    rd("mcycleh_carry", 12'hB80, 1'b0, 32'd1, 1'b0);
    rd("cycleh_shadow", 12'hC80, 1'b0, 32'd1, 1'b0);

    // minstret: retire alongside a trap is not counted
    bus.retire_v_i = 1'b1;
    step();
    bus.retire_v_i = 1'b1;
    trap(32'h0000_3000, 32'd4, 32'd0, 2'b11);
    step();
    bus.retire_v_i = 1'b1;
    step();
    rd("minstret_3pulse", 12'hB02, 1'b0, 32'd2, 1'b0);
    rd("instret_intent", 12'hC02, 1'b1, 32'd2, 1'b1);
    wr(12'hC02, 32'h0000_0099);
    step();
    rd("instret_ro_wr", 12'hB02, 1'b0, 32'd2, 1'b0);
    wr(12'hB02, 32'd10);
    bus.retire_v_i = 1'b1;
    step();
    rd("minstret_wr_override", 12'hC02, 1'b0, 32'd10, 1'b0);
    wr(12'hB82, 32'd5);
    step();
    rd("minstreth_wr", 12'hC82, 1'b0, 32'd5, 1'b0);
    rd("minstret_lo_kept", 12'hB02, 1'b0, 32'd10, 1'b0);

    // Reset overrides a same-cycle write and trap
    reset = 1'b1;
    wr(12'h340, 32'h0000_0001);
    trap(32'h0000_4000, 32'd5, 32'd1, 2'b00);
    step();
    rd("midrst_mscratch", 12'h340, 1'b0, 32'd0, 1'b0);
    outchk("midrst_mtvec", 3, MTV);
    outchk("midrst_mstatus", 4, 32'h0000_1800);
    outchk("midrst_mepc", 2, 32'd0);
    rd("midrst_mcycle", 12'hB00, 1'b0, 32'd0, 1'b0);
    reset = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
